keypad_scanner: RTL and testbench

Matrix keypad reader for the board's 4x4 keypad, the input-side counterpart of the multiplexed seven-segment display drivers. It strobes one column at a time, samples the returning rows, debounces whole-scan results, and delivers one 4-bit key code per press through a valid/acknowledge handshake. It sits between the keypad pins and user logic such as counters and timers, with the same clock as the display scan logic.

---
 rtl/keypad_scanner_pkg.sv | 22 ++
 rtl/keypad_scan_timer.sv | 52 +++++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: matrix geometry, scan-result encoding and key-code formula.
package keypad_scanner_pkg;

  localparam int KP_COLUMNS = 4;
  localparam int KP_ROWS    = 4;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_e;

  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] code;
  } scan_res_t;

  function automatic logic [3:0] kp_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column scan timing: dwell counter, rotating active-low column strobe, and
// single-cycle sample / end-of-scan strobes on the last dwell cycle of each column.
module keypad_scan_timer
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [KP_COLUMNS-1:0] column_strobe,
  output logic [1:0]            col_idx,
  output logic                  sample,
  output logic                  scan_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0]         dwell_q, dwell_d;
  logic [1:0]            col_q, col_d;
  logic [KP_COLUMNS-1:0] strobe_q, strobe_d;

  assign sample    = (dwell_q == DW'(SCAN_DIV - 1));
  assign scan_done = sample && (col_q == 2'd3);

  // The strobe is a registered rotation so the pins never glitch through a decode.
  always_comb begin
    dwell_d  = dwell_q + DW'(1);
    col_d    = col_q;
    strobe_d = strobe_q;
    if (sample) begin
      dwell_d  = '0;
      col_d    = col_q + 2'd1;
      strobe_d = {strobe_q[KP_COLUMNS-2:0], strobe_q[KP_COLUMNS-1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_q  <= '0;
      col_q    <= 2'd0;
      strobe_q <= 4'b1110;
    end else begin
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      strobe_q <= strobe_d;
    end
  end

  assign column_strobe = strobe_q;
  assign col_idx       = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad reader: synchronize rows, classify each full scan, debounce, and present
// one key code per press on a valid/ack handshake (event lands 1 cycle after the last sample).
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [KP_ROWS-1:0]    row_sense,
  input  logic                  key_ack,
  output logic [KP_COLUMNS-1:0] column_strobe,
  output logic [3:0]            key_code,
  output logic                  key_valid,
  output logic                  key_held,
  output logic                  overrun
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [KP_ROWS-1:0] meta_q, rows_q;
  logic [1:0]         col_idx;
  logic               sample, scan_done;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clock         (clock),
    .reset         (reset),
    .column_strobe (column_strobe),
    .col_idx       (col_idx),
    .sample        (sample),
    .scan_done     (scan_done)
  );

  logic [2:0] row_cnt, hit_sum;
  logic [1:0] row_idx, merged_cnt;
  logic [3:0] merged_code;
  logic [1:0] acc_cnt_q;
  logic [3:0] acc_code_q;
  scan_res_t  scan_res;

  always_comb begin
    row_cnt = '0;
    row_idx = '0;
    for (int r = 0; r < KP_ROWS; r++) begin
      if (!rows_q[r]) begin
        row_cnt = row_cnt + 3'd1;
        row_idx = r[1:0];
      end
    end
  end

  // Hit count saturates at 2: anything beyond one intersection is simply MULTI.
  assign hit_sum     = {1'b0, acc_cnt_q} + row_cnt;
  assign merged_cnt  = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
  assign merged_code = (acc_cnt_q == 2'd0) ? kp_code(row_idx, col_idx) : acc_code_q;

  always_comb begin
    scan_res.kind = RES_MULTI;
    scan_res.code = 4'd0;
    if (merged_cnt == 2'd0) begin
      scan_res.kind = RES_NONE;
    end else if (merged_cnt == 2'd1) begin
      scan_res.kind = RES_KEY;
      scan_res.code = merged_code;
    end
  end

  scan_res_t res_q, prev_q, prev_d, accepted_q, accepted_d;
  logic      res_vld_q;
  logic [SW-1:0] stable_q, stable_d;
  logic      press, release_evt;

  always_comb begin
    prev_d      = prev_q;
    stable_d    = stable_q;
    accepted_d  = accepted_q;
    press       = 1'b0;
    release_evt = 1'b0;
    if (res_vld_q) begin
      prev_d = res_q;
      if (res_q == prev_q) begin
        stable_d = (stable_q == SW'(DEBOUNCE_SCANS)) ? stable_q : stable_q + SW'(1);
      end else begin
        stable_d = SW'(1);
      end
      if (stable_d == SW'(DEBOUNCE_SCANS) && res_q != accepted_q && res_q.kind != RES_MULTI) begin
        press       = (res_q.kind == RES_KEY);
        release_evt = (accepted_q.kind == RES_KEY);
        accepted_d  = res_q;
      end
    end
  end

  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d, held_q, held_d, ovr_q, ovr_d, ack_eff;

  assign ack_eff = key_ack && valid_q;

  // A press that coincides with an ack replaces the consumed key instead of overrunning.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    held_d  = held_q;
    ovr_d   = ovr_q;
    if (press) begin
      held_d = 1'b1;
      if (valid_q && !ack_eff) begin
        ovr_d = 1'b1;
      end else begin
        code_d  = res_q.code;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end
    end else begin
      if (release_evt) held_d = 1'b0;
      if (ack_eff) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q     <= '1;
      rows_q     <= '1;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      prev_q     <= '0;
      stable_q   <= '0;
      accepted_q <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      meta_q    <= row_sense;
      rows_q    <= meta_q;
      res_vld_q <= scan_done;
      if (sample) begin
        if (scan_done) begin
          acc_cnt_q  <= 2'd0;
          acc_code_q <= 4'd0;
          res_q      <= scan_res;
        end else begin
          acc_cnt_q  <= merged_cnt;
          acc_code_q <= merged_code;
        end
      end
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      accepted_q <= accepted_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      ovr_q      <= ovr_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad pin model, scripted plus random per-scan key sets,
// and a scan-level reference model of debounce and handshake.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_sense;
  logic       key_ack = 1'b0;
  logic [3:0] column_strobe;
  logic [3:0] key_code;
  logic       key_valid, key_held, overrun;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clock         (clock),
    .reset         (reset),
    .row_sense     (row_sense),
    .key_ack       (key_ack),
    .column_strobe (column_strobe),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_held      (key_held),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  logic [15:0] keys_mask = 16'h0;
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!column_strobe[c] && keys_mask[r*4+c]) row_sense[r] = 1'b0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: results as ints, -1 = nothing pressed, 0..15 = key, 16 = several keys.
  int         m_prev = -1, m_stable = 0, m_acc = -1;
  logic [3:0] m_code = 4'd0;
  bit         m_valid = 0, m_held = 0, m_ovr = 0;

  function automatic int scan_result(input logic [15:0] k);
    int n, idx;
    n = 0; idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n == 1) return idx;
    return 16;
  endfunction

  task automatic model_step(input bit have_res, input int r, input bit ack);
    bit press, rel;
    press = 0; rel = 0;
    if (have_res) begin
      m_stable = (r == m_prev) ? ((m_stable < DEB) ? m_stable + 1 : DEB) : 1;
      m_prev   = r;
      if (m_stable == DEB && r != m_acc && r != 16) begin
        press = (r >= 0);
        rel   = (m_acc >= 0);
        m_acc = r;
      end
    end
    if (ack && m_valid) begin
      m_valid = 0;
      m_ovr   = 0;
    end
    if (press) begin
      if (m_valid) m_ovr = 1;
      else begin
        m_valid = 1;
        m_code  = r[3:0];
      end
    end
    m_held = press ? 1'b1 : (rel ? 1'b0 : m_held);
  endtask

  int          edge_k = 0;
  bit          have_prev = 0;
  logic [15:0] prev_keys = 16'h0;

  function automatic logic [3:0] exp_strobe(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((k / SCAN_DIV) % 4));
  endfunction

  // Entered on the falling edge right after a scan boundary; leaves on the next one.
  task automatic run_scan(input logic [15:0] keys, input bit ack);
    keys_mask = keys;
    key_ack   = ack;
    @(posedge clock); edge_k++;
    @(negedge clock);
    model_step(have_prev, scan_result(prev_keys), ack);
    check("key_code",  32'(key_code),  32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held",  32'(key_held),  32'(m_held));
    check("overrun",   32'(overrun),   32'(m_ovr));
    check("strobe",    32'(column_strobe), 32'(exp_strobe(edge_k)));
    key_ack = 1'b0;
    repeat (4 * SCAN_DIV - 1) begin
      @(posedge clock); edge_k++;
      @(negedge clock);
      check("strobe", 32'(column_strobe), 32'(exp_strobe(edge_k)));
    end
    prev_keys = keys;
    have_prev = 1;
  endtask

  logic [16:0] stim[$];

  task automatic add(input logic [15:0] m, input int n, input bit ack_first);
    for (int i = 0; i < n; i++) stim.push_back({(i == 0) ? ack_first : 1'b0, m});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, a, b, dur;
    logic [15:0] m;

    repeat (3) @(negedge clock);
    check("rst_strobe", 32'(column_strobe), 32'h0000_000E);
    check("rst_code",   32'(key_code),  32'h0);
    check("rst_valid",  32'(key_valid), 32'h0);
    check("rst_held",   32'(key_held),  32'h0);
    check("rst_ovr",    32'(overrun),   32'h0);

    add(16'h0000, 2, 0);
    add(16'h0200, 5, 0);
    add(16'h0000, 4, 1);
    add(16'h0200, 1, 0); add(16'h0000, 1, 0);
    add(16'h0200, 1, 0); add(16'h0000, 1, 0);
    add(16'h0200, 4, 0);
    add(16'h0000, 4, 0);
    add(16'h0001, 4, 0);
    add(16'h0000, 4, 1);
    add(16'h8000, 4, 0);
    add(16'h8001, 4, 0);
    add(16'h0000, 4, 0);
    add(16'h0020, 3, 0);
    add(16'h0020, 1, 1);
    add(16'h0000, 4, 1);
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      dur  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + 1 + $urandom_range(0, 14)) % 16;
      m    = 16'h0;
      if (kind >= 4) m[a] = 1'b1;
      if (kind == 9) m[b] = 1'b1;
      for (int i = 0; i < dur; i++) stim.push_back({($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, m});
    end
    add(16'h0000, 4, 0);
    add(16'h0008, 4, 0);

    reset  = 1'b1;
    edge_k = 0;
    foreach (stim[i]) run_scan(stim[i][15:0], stim[i][16]);

    check("pre_rst_valid", 32'(key_valid), 32'(m_valid));
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_strobe", 32'(column_strobe), 32'h0000_000E);
    check("arst_code",   32'(key_code),  32'h0);
    check("arst_valid",  32'(key_valid), 32'h0);
    check("arst_held",   32'(key_held),  32'h0);
    check("arst_ovr",    32'(overrun),   32'h0);
    repeat (2) @(negedge clock);
    check("arst_hold_strobe", 32'(column_strobe), 32'h0000_000E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
